// File: rtl/alu_arb_if.sv
// alu_arb_if -- bundle of every non-clock/reset signal of alu_arb.
//
// Signals (directions as seen by the arbiter, modport slave):
//   req_valid  in   [1:0]        per-requester request valid
//   req_ready  out  [1:0]        per-requester accept strobe
//   req_a0/b0  in   [WIDTH-1:0]  operands of requester 0
//   req_a1/b1  in   [WIDTH-1:0]  operands of requester 1
//   req_op0/1  in   [1:0]        opcode of each requester (uninterpreted)
//   alu_a/b    out  [WIDTH-1:0]  operands to the shared external ALU
//   alu_op     out  [1:0]        opcode to the shared external ALU
//   alu_y      in   [WIDTH-1:0]  shared ALU result
//   rsp_valid  out  [1:0]        per-requester result valid
//   rsp_ready  in   [1:0]        per-requester result accept
//   rsp_y      out  [WIDTH-1:0]  registered result, common to both requesters
//   busy       out               high whenever the arbiter is not idle
// The master modport is the requester/ALU environment side.

interface alu_arb_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_y;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  alu_y, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output alu_y, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, busy
    );
endinterface

// File: rtl/alu_arb.sv
// alu_arb -- arbitrates two requesters onto one shared combinational ALU.
//
// A request is accepted in IDLE, its operands are held on the ALU port while
// the FSM sits in EXEC for one cycle, the ALU result is registered, and the
// result is offered to the owner in RESP until that owner accepts it.
// Accepts are therefore at best one every three cycles.
//
// Ports:
//   clk  in   sole clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  alu_arb_if.slave, see rtl/alu_arb_if.sv
//
// Configuration macro ALU_ARB_RR_EN:
//   defined   -> round-robin between the two requesters when both are valid
//   undefined -> fixed priority, requester 0 wins; no grant pointer exists

module alu_arb #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [1:0]       cap_op;
    logic [WIDTH-1:0] rsp_y_q;

    logic [1:0]       grant;
    logic [1:0]       req_ready_c;
    logic [1:0]       rsp_valid_c;
    logic             transfer;
    logic             winner;

    // ------------------------------------------------------------------
    // Grant selection (pure function of the current request vector)
    // ------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    // Index of the requester granted by the most recent transfer.
    logic last_grant;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (transfer) begin
            last_grant <= winner;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (bus.req_valid[0]) begin
            grant = 2'b01;
        end else if (bus.req_valid[1]) begin
            grant = 2'b10;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        req_ready_c = 2'b00;
        rsp_valid_c = 2'b00;
        case (state)
            IDLE: begin
                // Reset wins: no requester may see an accept while rst is high.
                if (!rst) begin
                    req_ready_c = grant;
                end
                if (req_ready_c != 2'b00) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_c = owner ? 2'b10 : 2'b01;
                // Only the owner's accept counts; the other bit is ignored.
                if (bus.rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign transfer = |(bus.req_valid & req_ready_c);
    assign winner   = req_ready_c[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: every register here, including the data path, has a
            // defined reset value because the ALU port and rsp_y are
            // externally visible right after reset.
            state   <= IDLE;
            owner   <= 1'b0;
            cap_a   <= '0;
            cap_b   <= '0;
            cap_op  <= 2'b00;
            rsp_y_q <= '0;
        end else begin
            state <= state_nxt;
            // Captured operands only change on a transfer, so the ALU inputs
            // never follow requests arriving while the block is busy.
            if (transfer) begin
                owner  <= winner;
                cap_a  <= winner ? bus.req_a1  : bus.req_a0;
                cap_b  <= winner ? bus.req_b1  : bus.req_b0;
                cap_op <= winner ? bus.req_op1 : bus.req_op0;
            end
            if (state == EXEC) begin
                rsp_y_q <= bus.alu_y;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.alu_a     = cap_a;
    assign bus.alu_b     = cap_b;
    assign bus.alu_op    = cap_op;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb -- scoreboard bench for alu_arb.
//
// Stimulus (directed sequences plus $urandom traffic) is driven just after
// each rising edge. A negedge monitor keeps a transaction-level model of the
// arbiter: whether a transaction is outstanding, the grant rule, and a queue
// of expected responses (owner, ALU result, earliest cycle). Every cycle it
// compares req_ready, busy, the ALU operand port, rsp_valid and rsp_y
// against that model. The bench also acts as the external ALU; outside the
// EXEC cycle it XORs noise into alu_y so a wrongly timed capture shows up.
// ALU_ARB_RR_EN selects the expected grant rule, matching the RTL build.

module tb_alu_arb;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arb_if #(.WIDTH(WIDTH)) bus ();

    alu_arb #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] y;
        int               due;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } grant_t;

    exp_t   exp_q[$];
    grant_t glog[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state
    bit               mon_en;
    bit               outstanding;
    logic             last_g;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [1:0]       m_op;
    logic [1:0]       accepted;
    logic [WIDTH-1:0] noise;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] alu_f(logic [WIDTH-1:0] a,
                                               logic [WIDTH-1:0] b,
                                               logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_y = alu_f(bus.alu_a, bus.alu_b, bus.alu_op) ^ noise;

    function automatic logic [1:0] exp_grant(logic [1:0] v);
        if (v != 2'b11) return v;
`ifdef ALU_ARB_RR_EN
        return last_g ? 2'b01 : 2'b10;
`else
        return 2'b01;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic monitor_step();
        logic [1:0] eg;
        logic [1:0] rv_exp;
        int         idx;
        accepted = bus.req_valid & bus.req_ready;
        if (!mon_en) return;
        if (rst) begin
            check("req_ready_during_rst", {30'd0, bus.req_ready}, 0);
            outstanding = 0;
            exp_q.delete();
            last_g = 1'b1;
            m_a    = '0;
            m_b    = '0;
            m_op   = 2'b00;
            noise  = WIDTH'($urandom);
            return;
        end
        eg = outstanding ? 2'b00 : exp_grant(bus.req_valid);
        rv_exp = 2'b00;
        if (outstanding && exp_q.size() > 0 && exp_q[0].due <= cyc)
            rv_exp = (exp_q[0].id == 1) ? 2'b10 : 2'b01;

        check("req_ready", {30'd0, bus.req_ready}, {30'd0, eg});
        check("busy", {31'd0, bus.busy}, {31'd0, outstanding});
        check("alu_a_hold", {28'd0, bus.alu_a}, {28'd0, m_a});
        check("alu_b_hold", {28'd0, bus.alu_b}, {28'd0, m_b});
        check("alu_op_hold", {30'd0, bus.alu_op}, {30'd0, m_op});
        check("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, rv_exp});
        if (rv_exp != 2'b00)
            check("rsp_y", {28'd0, bus.rsp_y}, {28'd0, exp_q[0].y});

        if (accepted != 2'b00)
            glog.push_back('{accepted[1] ? 1 : 0, cyc});

        // Clean ALU output only during the cycle the result is captured.
        if (outstanding && exp_q.size() > 0 && exp_q[0].due == cyc + 1)
            noise = '0;
        else
            noise = WIDTH'($urandom);

        if (eg != 2'b00) begin
            idx  = eg[1] ? 1 : 0;
            m_a  = eg[1] ? bus.req_a1  : bus.req_a0;
            m_b  = eg[1] ? bus.req_b1  : bus.req_b0;
            m_op = eg[1] ? bus.req_op1 : bus.req_op0;
            exp_q.push_back('{idx, alu_f(m_a, m_b, m_op), cyc + 2});
            outstanding = 1;
            last_g = eg[1];
        end else if (rv_exp != 2'b00 && bus.rsp_ready[exp_q[0].id]) begin
            void'(exp_q.pop_front());
            outstanding = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int i);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!accepted[i] && k < 20);
        check($sformatf("accept_req%0d", i), {31'd0, accepted[i]}, 1);
    endtask

    task automatic drain();
        int k = 0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        while (outstanding && k < 20) begin
            tick();
            k++;
        end
        check("drain_idle", {31'd0, outstanding}, 0);
    endtask

    task automatic rand_ops(input int i);
        if (i == 0) begin
            bus.req_a0  = WIDTH'($urandom);
            bus.req_b0  = WIDTH'($urandom);
            bus.req_op0 = 2'($urandom_range(0, 3));
        end else begin
            bus.req_a1  = WIDTH'($urandom);
            bus.req_b1  = WIDTH'($urandom);
            bus.req_op1 = 2'($urandom_range(0, 3));
        end
    endtask

    // Both requesters valid every cycle, results always accepted.
    task automatic stream(input int n);
        glog.delete();
        rand_ops(0);
        rand_ops(1);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int c = 0; c < n; c++) begin
            tick();
            for (int i = 0; i < 2; i++) if (accepted[i]) rand_ops(i);
        end
        drain();
        check("stream_grant_count", {31'd0, glog.size() >= 4}, 1);
        for (int k = 1; k < glog.size(); k++) begin
            check("stream_spacing", glog[k].cyc - glog[k-1].cyc, 3);
`ifdef ALU_ARB_RR_EN
            check("rr_alternate", glog[k].id, 1 - glog[k-1].id);
`else
            check("fixed_prio_req0", glog[k].id, 0);
`endif
        end
    endtask

    task automatic run_random(input int n);
        logic [1:0] pend = 2'b00;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (accepted[i]) pend[i] = 1'b0;
                if (!pend[i]) begin
                    // Idle requesters wiggle their operands freely.
                    rand_ops(i);
                    if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
                end
            end
            bus.req_valid = pend;
            bus.rsp_ready = 2'($urandom);
            tick();
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        mon_en        = 0;
        outstanding   = 0;
        last_g        = 1'b1;
        m_a           = '0;
        m_b           = '0;
        m_op          = 2'b00;
        noise         = '0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.req_a0    = 4'h1;
        bus.req_b0    = 4'h2;
        bus.req_op0   = 2'd0;
        bus.req_a1    = 4'h3;
        bus.req_b1    = 4'h4;
        bus.req_op1   = 2'd1;

        // Reset state, with both requests pending while rst is high
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {30'd0, bus.req_ready}, 0);
        check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_rsp_y", {28'd0, bus.rsp_y}, 0);
        check("rst_alu_a", {28'd0, bus.alu_a}, 0);
        check("rst_alu_b", {28'd0, bus.alu_b}, 0);
        check("rst_alu_op", {30'd0, bus.alu_op}, 0);
        mon_en = 1;
        bus.req_valid = 2'b00;
        tick();
        rst = 1'b0;

        // Single request: 3 + 5 = 8, response two cycles after transfer
        bus.req_a0    = 4'h3;
        bus.req_b0    = 4'h5;
        bus.req_op0   = 2'd0;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b01;
        wait_accept(0);
        bus.req_valid = 2'b00;
        tick();
        check("single_rsp_valid", {30'd0, bus.rsp_valid}, 2'b01);
        check("single_rsp_y", {28'd0, bus.rsp_y}, 4'h8);
        drain();

        // Response back-pressure: only the non-owner accepts for 5 cycles
        bus.req_a0    = 4'h9;
        bus.req_b0    = 4'h2;
        bus.req_op0   = 2'd1;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b10;
        wait_accept(0);
        bus.req_valid = 2'b00;
        tick();
        repeat (5) tick();
        check("hold_busy", {31'd0, bus.busy}, 1);
        check("hold_rsp_y", {28'd0, bus.rsp_y}, 4'h7);
        bus.rsp_ready = 2'b01;
        tick();
        check("release_busy", {31'd0, bus.busy}, 0);
        check("release_rsp_valid", {30'd0, bus.rsp_valid}, 0);
        drain();

        // Reset pulsed in EXEC; then only requester 1 asks (6 & 3 = 2)
        bus.req_a0    = 4'h1;
        bus.req_b0    = 4'h1;
        bus.req_op0   = 2'd0;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b11;
        wait_accept(0);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_exec_busy", {31'd0, bus.busy}, 0);
        check("rst_exec_rsp_valid", {30'd0, bus.rsp_valid}, 0);
        check("rst_exec_rsp_y", {28'd0, bus.rsp_y}, 0);
        bus.req_a1    = 4'h6;
        bus.req_b1    = 4'h3;
        bus.req_op1   = 2'd2;
        bus.req_valid = 2'b10;
        wait_accept(1);
        bus.req_valid = 2'b00;
        drain();

        // Both requesters continuously valid
        stream(30);

        // Randomized traffic with random response acceptance
        run_random(2000);

        // A second saturated stream after random history
        stream(30);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
